// File: rtl/rv32i_pkg.sv
// ============================================================================
// rv32i_pkg : shared RV32I constants, fetch FSM encoding and opcode values
// Revision  : 1.0
// ============================================================================
`default_nettype none

package rv32i_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// ============================================================================
// fetch_stage_if : instruction-memory, redirect and decoder-side signals
// Revision       : 1.0
// ============================================================================
`default_nettype none

interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] instruccion;
  logic [31:0] pc_out;
  logic        fetch_misaligned;

  modport master (
    output imem_req, imem_addr, if_valid, instruccion, pc_out, fetch_misaligned,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, instruccion, pc_out, fetch_misaligned,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage_pc_gen.sv
// ============================================================================
// pc_gen   : program counter with redirect/increment/hold mux and misalignment flag
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_gen
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  wire         clk,
  input  wire         rst_n,
  input  wire         redirect_valid,
  input  wire  [31:0] redirect_pc,
  input  wire         advance,
  output logic [31:0] pc,
  output logic        misaligned
);

  logic [31:0] pc_d, pc_q;
  logic        mis_d, mis_q;

  // Redirect wins over advance; the flag is registered so it pulses the cycle after.
  always_comb begin
    pc_d  = pc_q;
    mis_d = 1'b0;
    if (redirect_valid) begin
      pc_d  = align_word(redirect_pc);
      mis_d = |redirect_pc[1:0];
    end else if (advance) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end

  assign pc         = pc_q;
  assign misaligned = mis_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : RV32I fetch FSM with single-entry IF/ID buffer
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  wire           clk,
  input  wire           rst_n,
  fetch_stage_if.master bus
);

  fetch_state_e state_d, state_q;
  logic         valid_d, valid_q;
  logic [31:0]  instr_d, instr_q;
  logic [31:0]  pc_out_d, pc_out_q;
  logic         req;
  logic         advance;
  logic         transfer;
  logic [31:0]  pc;
  logic         misaligned;

  assign transfer = valid_q && bus.id_ready;

  pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (bus.redirect_valid),
    .redirect_pc    (bus.redirect_pc),
    .advance        (advance),
    .pc             (pc),
    .misaligned     (misaligned)
  );

  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    advance  = 1'b0;
    valid_d  = valid_q && !transfer;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.redirect_valid && (!valid_q || bus.id_ready)) begin
          req     = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.redirect_valid) begin
          state_d = bus.imem_rvalid ? ST_IDLE : ST_DROP;
        end else if (bus.imem_rvalid) begin
          valid_d  = 1'b1;
          instr_d  = bus.imem_rdata;
          pc_out_d = pc;
          advance  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (bus.imem_rvalid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A redirect squashes any same-cycle transfer and empties the buffer.
    if (bus.redirect_valid) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      instr_q  <= NOP_INSTR;
      pc_out_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  end

  // Request is combinational from IDLE, so it is held off while reset is asserted.
  assign bus.imem_req         = req && rst_n;
  assign bus.imem_addr        = pc;
  assign bus.if_valid         = valid_q;
  assign bus.instruccion      = instr_q;
  assign bus.pc_out           = pc_out_q;
  assign bus.fetch_misaligned = misaligned;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : directed vector bench for fetch_stage
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  typedef struct {
    logic        rst_n;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        id_ready;
    logic        chk;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        chk_buf;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fetch_stage_if bus_if ();

  fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic r, input logic rv, input logic [31:0] rd, input logic rdv,
    input logic [31:0] rp, input logic idr, input logic c, input logic eq,
    input logic [31:0] ea, input logic ev, input logic cb, input logic [31:0] ei,
    input logic [31:0] ep, input logic em);
    vec_t v;
    v.rst_n = r;   v.rvalid = rv;  v.rdata = rd;   v.redir = rdv;
    v.rpc = rp;    v.id_ready = idr; v.chk = c;    v.e_req = eq;
    v.e_addr = ea; v.e_valid = ev; v.chk_buf = cb; v.e_instr = ei;
    v.e_pc = ep;   v.e_mis = em;
    return v;
  endfunction

  task automatic chk32(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic run_vec(input string nm, input int idx, input vec_t v);
    rst_n                 = v.rst_n;
    bus_if.imem_rvalid    = v.rvalid;
    bus_if.imem_rdata     = v.rdata;
    bus_if.redirect_valid = v.redir;
    bus_if.redirect_pc    = v.rpc;
    bus_if.id_ready       = v.id_ready;
    @(negedge clk);
    if (v.chk) begin
      chk32({nm, ".imem_req"},  idx, {31'd0, bus_if.imem_req},         {31'd0, v.e_req});
      chk32({nm, ".imem_addr"}, idx, bus_if.imem_addr,                 v.e_addr);
      chk32({nm, ".if_valid"},  idx, {31'd0, bus_if.if_valid},         {31'd0, v.e_valid});
      chk32({nm, ".misalign"},  idx, {31'd0, bus_if.fetch_misaligned}, {31'd0, v.e_mis});
      if (v.chk_buf) begin
        chk32({nm, ".instr"},  idx, bus_if.instruccion, v.e_instr);
        chk32({nm, ".pc_out"}, idx, bus_if.pc_out,      v.e_pc);
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [16];

  initial begin
    checks   = 0;
    failures = 0;

    // Reset, L=1 streaming at 0x0/0x4/0x8, then a 5-cycle id_ready stall.
    tbl[0]  = mk(0,0,0,0,0,1, 0, 0,0,0, 0,0,0,0);
    tbl[1]  = mk(0,0,0,0,0,1, 1, 0,32'h0,0, 1,NOP,32'h0,0);
    tbl[2]  = mk(1,0,0,0,0,1, 1, 1,32'h0,0, 0,0,0,0);
    tbl[3]  = mk(1,1,32'hA000_0000,0,0,1, 1, 0,32'h0,0, 0,0,0,0);
    tbl[4]  = mk(1,0,0,0,0,1, 1, 1,32'h4,1, 1,32'hA000_0000,32'h0,0);
    tbl[5]  = mk(1,1,32'hA000_0004,0,0,1, 1, 0,32'h4,0, 0,0,0,0);
    tbl[6]  = mk(1,0,0,0,0,1, 1, 1,32'h8,1, 1,32'hA000_0004,32'h4,0);
    tbl[7]  = mk(1,1,32'hA000_0008,0,0,1, 1, 0,32'h8,0, 0,0,0,0);
    for (int i = 8; i < 13; i++)
      tbl[i] = mk(1,0,0,0,0,0, 1, 0,32'hC,1, 1,32'hA000_0008,32'h8,0);
    tbl[13] = mk(1,0,0,0,0,1, 1, 1,32'hC,1, 1,32'hA000_0008,32'h8,0);
    tbl[14] = mk(1,1,32'hA000_000C,0,0,1, 1, 0,32'hC,0, 0,0,0,0);
    tbl[15] = mk(1,0,0,0,0,0, 1, 0,32'h10,1, 1,32'hA000_000C,32'hC,0);

    for (int i = 0; i < 16; i++) run_vec("tbl", i, tbl[i]);

    // Redirect to 0x100 while WAIT with L=3; the stale word must never show.
    run_vec("rd_wait", 0, mk(1,0,0,0,0,1, 1, 1,32'h10,1, 1,32'hA000_000C,32'hC,0));
    run_vec("rd_wait", 1, mk(1,0,0,0,0,1, 1, 0,32'h10,0, 0,0,0,0));
    run_vec("rd_wait", 2, mk(1,0,0,1,32'h100,1, 1, 0,32'h10,0, 0,0,0,0));
    run_vec("rd_wait", 3, mk(1,1,32'hDEAD_BEEF,0,0,1, 1, 0,32'h100,0, 0,0,0,0));
    run_vec("rd_wait", 4, mk(1,0,0,0,0,1, 1, 1,32'h100,0, 0,0,0,0));
    run_vec("rd_wait", 5, mk(1,1,32'hA000_0100,0,0,1, 1, 0,32'h100,0, 0,0,0,0));
    run_vec("rd_wait", 6, mk(1,0,0,0,0,0, 1, 0,32'h104,1, 1,32'hA000_0100,32'h100,0));

    // Redirect coinciding with the response: word discarded, request next cycle.
    run_vec("rd_rsp", 0, mk(1,0,0,0,0,1, 1, 1,32'h104,1, 1,32'hA000_0100,32'h100,0));
    run_vec("rd_rsp", 1, mk(1,1,32'hA000_0104,1,32'h200,1, 1, 0,32'h104,0, 0,0,0,0));
    run_vec("rd_rsp", 2, mk(1,0,0,0,0,1, 1, 1,32'h200,0, 0,0,0,0));
    run_vec("rd_rsp", 3, mk(1,1,32'hA000_0200,0,0,1, 1, 0,32'h200,0, 0,0,0,0));
    run_vec("rd_rsp", 4, mk(1,0,0,0,0,0, 1, 0,32'h204,1, 1,32'hA000_0200,32'h200,0));

    // Misaligned redirect to 0x102 with a squashed same-cycle transfer.
    run_vec("misal", 0, mk(1,0,0,1,32'h102,1, 1, 0,32'h204,1, 1,32'hA000_0200,32'h200,0));
    run_vec("misal", 1, mk(1,0,0,0,0,0, 1, 1,32'h100,0, 0,0,0,1));
    run_vec("misal", 2, mk(1,1,32'hA000_0100,0,0,0, 1, 0,32'h100,0, 0,0,0,0));
    run_vec("misal", 3, mk(1,0,0,0,0,0, 1, 0,32'h104,1, 1,32'hA000_0100,32'h100,0));

    // Reset while WAIT; the late response lands in IDLE and is ignored.
    run_vec("rst_wait", 0, mk(1,0,0,0,0,1, 1, 1,32'h104,1, 1,32'hA000_0100,32'h100,0));
    run_vec("rst_wait", 1, mk(0,0,0,0,0,1, 1, 0,32'h104,0, 0,0,0,0));
    run_vec("rst_wait", 2, mk(0,0,0,0,0,1, 1, 0,32'h0,0, 1,NOP,32'h0,0));
    run_vec("rst_wait", 3, mk(1,1,32'hBAD0_BAD0,0,0,1, 1, 1,32'h0,0, 0,0,0,0));
    run_vec("rst_wait", 4, mk(1,1,32'hA000_0000,0,0,1, 1, 0,32'h0,0, 0,0,0,0));
    run_vec("rst_wait", 5, mk(1,0,0,0,0,0, 1, 0,32'h4,1, 1,32'hA000_0000,32'h0,0));

    // PC wrap from 0xFFFF_FFFC to 0.
    run_vec("wrap", 0, mk(1,0,0,1,32'hFFFF_FFFC,0, 1, 0,32'h4,1, 1,32'hA000_0000,32'h0,0));
    run_vec("wrap", 1, mk(1,0,0,0,0,1, 1, 1,32'hFFFF_FFFC,0, 0,0,0,0));
    run_vec("wrap", 2, mk(1,1,32'h1234_5678,0,0,1, 1, 0,32'hFFFF_FFFC,0, 0,0,0,0));
    run_vec("wrap", 3, mk(1,0,0,0,0,1, 1, 1,32'h0,1, 1,32'h1234_5678,32'hFFFF_FFFC,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
